// File: rtl/loader_fsm.sv
// Byte-stream program loader: receives a word count, big-endian 16-bit words and an XOR checksum,
// writes the words into RAM and releases the CPU from reset only when the checksum matches.
module loader_fsm #(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WORD_SIZE-1:0]  ram_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      StIdle,
      StCount,
      StHi,
      StLo,
      StWrite,
      StCheck,
      StDone,
      StErr
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

   state_e     state_q;
   logic [8:0] remain_q;
   logic [7:0] hi_q;
   logic [7:0] csum_q;
   logic       accept;

   always_comb begin
      in_ready = (state_q == StCount) || (state_q == StHi) ||
                 (state_q == StLo)    || (state_q == StCheck);
   end

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         remain_q  <= '0;
         hi_q      <= '0;
         csum_q    <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= BaseAddr;
         ram_wdata <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         unique case (state_q)
            StIdle, StDone, StErr: begin
               if (start) begin
                  state_q   <= StCount;
                  csum_q    <= '0;
                  ram_addr  <= BaseAddr;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
               end
            end
            StCount: begin
               if (accept) begin
                  // A count byte of zero encodes a full 256-word image.
                  remain_q <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  csum_q   <= csum_q ^ in_data;
                  state_q  <= StHi;
               end
            end
            StHi: begin
               if (accept) begin
                  hi_q    <= in_data;
                  csum_q  <= csum_q ^ in_data;
                  state_q <= StLo;
               end
            end
            StLo: begin
               if (accept) begin
                  ram_wdata <= WORD_SIZE'({hi_q, in_data});
                  ram_we    <= 1'b1;
                  csum_q    <= csum_q ^ in_data;
                  state_q   <= StWrite;
               end
            end
            StWrite: begin
               ram_addr <= ram_addr + ADDR_WIDTH'(1);
               remain_q <= remain_q - 9'd1;
               state_q  <= (remain_q == 9'd1) ? StCheck : StHi;
            end
            StCheck: begin
               if (accept) begin
                  busy <= 1'b0;
                  if (in_data == csum_q) begin
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                     state_q   <= StDone;
                  end else begin
                     error     <= 1'b1;
                     cpu_reset <= 1'b1;
                     state_q   <= StErr;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_loader_fsm.sv
// Directed bench for loader_fsm: two instances (base 0 and base 254), RAM writes checked
// against a scoreboard queue filled as words are driven.
module tb_loader_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;

   logic        rdy0, we0, cpur0, busy0, done0, err0;
   logic [7:0]  addr0;
   logic [15:0] wd0;
   logic        rdy1, we1, cpur1, busy1, done1, err1;
   logic [7:0]  addr1;
   logic [15:0] wd1;

   int          total = 0;
   int          bad = 0;
   int          sel = 0;
   logic [23:0] q0[$];
   logic [23:0] q1[$];
   logic [15:0] words[256];

   always #5 clk = ~clk;

   loader_fsm #(.WORD_SIZE(16), .ADDR_WIDTH(8), .BASE_ADDR(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .ram_we(we0), .ram_addr(addr0), .ram_wdata(wd0),
      .cpu_reset(cpur0), .busy(busy0), .done(done0), .error(err0)
   );

   loader_fsm #(.WORD_SIZE(16), .ADDR_WIDTH(8), .BASE_ADDR(254)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .ram_we(we1), .ram_addr(addr1), .ram_wdata(wd1),
      .cpu_reset(cpur1), .busy(busy1), .done(done1), .error(err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we0 === 1'b1) begin
         if (q0.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_we0 observed=%0h expected=none", {addr0, wd0});
         end else begin
            chk("wr0", {8'h00, addr0, wd0}, {8'h00, q0.pop_front()});
         end
      end
      if (we1 === 1'b1) begin
         if (q1.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_we1 observed=%0h expected=none", {addr1, wd1});
         end else begin
            chk("wr1", {8'h00, addr1, wd1}, {8'h00, q1.pop_front()});
         end
      end
   end

   function automatic logic cur_rdy();
      return (sel != 0) ? rdy1 : rdy0;
   endfunction

   task automatic pulse_start();
      if (sel != 0) start1 = 1'b1;
      else start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Optional random idle cycles (with stray start pulses) before presenting the byte.
   task automatic send(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               if (sel != 0) start1 = 1'b1;
               else start0 = 1'b1;
            end
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (cur_rdy() !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n == 50) begin
         total++;
         bad++;
         $error("FAIL handshake_timeout observed=in_ready_low expected=in_ready_high");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic load(input int base, input logic [7:0] cnt, input bit bad_sum, input bit gaps);
      logic [7:0] cs;
      logic [7:0] a;
      int         nw;
      nw = (cnt == 8'd0) ? 256 : int'(cnt);
      pulse_start();
      cs = cnt;
      send(cnt, gaps);
      for (int i = 0; i < nw; i++) begin
         a = 8'((base + i) % 256);
         if (sel != 0) q1.push_back({a, words[i]});
         else q0.push_back({a, words[i]});
         send(words[i][15:8], gaps);
         send(words[i][7:0], gaps);
         cs = cs ^ words[i][15:8] ^ words[i][7:0];
      end
      send(cs ^ {7'd0, bad_sum}, gaps);
   endtask

   task automatic check_end(input string tag, input bit good, input logic [7:0] exp_addr);
      if (sel != 0) begin
         chk({tag, "_done"}, done1, good);
         chk({tag, "_error"}, err1, !good);
         chk({tag, "_cpu_reset"}, cpur1, !good);
         chk({tag, "_busy"}, busy1, 1'b0);
         chk({tag, "_addr"}, addr1, exp_addr);
         chk({tag, "_pending"}, q1.size(), 0);
      end else begin
         chk({tag, "_done"}, done0, good);
         chk({tag, "_error"}, err0, !good);
         chk({tag, "_cpu_reset"}, cpur0, !good);
         chk({tag, "_busy"}, busy0, 1'b0);
         chk({tag, "_addr"}, addr0, exp_addr);
         chk({tag, "_pending"}, q0.size(), 0);
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_reset", cpur0, 1'b1);
      chk("rst_we", we0, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_error", err0, 1'b0);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_addr0", addr0, 8'd0);
      chk("rst_addr1", addr1, 8'd254);
      chk("rst_wdata", wd0, 16'h0000);
      chk("rst_ready", rdy0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Two-word image with correct checksum
      sel = 0;
      words[0] = 16'hE202;
      words[1] = 16'hE303;
      load(0, 8'd2, 1'b0, 1'b0);
      check_end("good2", 1'b1, 8'd2);
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", done0, 1'b1);
      chk("done_ready", rdy0, 1'b0);

      // Same image, checksum off by one
      load(0, 8'd2, 1'b1, 1'b0);
      check_end("badsum", 1'b0, 8'd2);

      // Full 256-word image, address wraps back to 0
      fill_random(256);
      load(0, 8'd0, 1'b0, 1'b0);
      check_end("full256", 1'b1, 8'd0);

      // Base 254, three words: 254, 255, 0
      sel = 1;
      fill_random(3);
      load(254, 8'd3, 1'b0, 1'b0);
      check_end("base254", 1'b1, 8'd1);
      sel = 0;

      // Same words gap-free then with random in_valid gaps and stray start pulses
      fill_random(5);
      load(0, 8'd5, 1'b0, 1'b0);
      check_end("nogap", 1'b1, 8'd5);
      load(0, 8'd5, 1'b0, 1'b1);
      check_end("gaps", 1'b1, 8'd5);
      load(0, 8'd5, 1'b1, 1'b1);
      check_end("gaps_bad", 1'b0, 8'd5);

      // Reset while waiting for the low byte
      pulse_start();
      send(8'd2, 1'b0);
      send(8'hAB, 1'b0);
      chk("lo_busy", busy0, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'hCD;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      chk("midrst_busy", busy0, 1'b0);
      chk("midrst_cpu_reset", cpur0, 1'b1);
      chk("midrst_we", we0, 1'b0);
      chk("midrst_ready", rdy0, 1'b0);
      chk("midrst_addr", addr0, 8'd0);
      chk("midrst_done", done0, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Reset dominates start on the same edge
      reset  = 1'b0;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      reset  = 1'b1;
      start0 = 1'b0;
      chk("rst_vs_start_busy", busy0, 1'b0);
      chk("rst_vs_start_ready", rdy0, 1'b0);

      fill_random(4);
      load(0, 8'd4, 1'b0, 1'b0);
      check_end("after_rst", 1'b1, 8'd4);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/loader_fsm.md
LOADER_FSM -- requirements
Module: loader_fsm

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of one RAM word/instruction.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width (256 words).
REQ-003 Parameter BASE_ADDR, default 0, RAM address of the first loaded word.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  loader can accept a byte this cycle.
REQ-010 ram_we  output  1  RAM write enable, one-cycle pulse per word.
REQ-011 ram_addr  output  ADDR_WIDTH  RAM write address.
REQ-012 ram_wdata  output  WORD_SIZE  RAM write data.
REQ-013 cpu_reset  output  1  active-high reset to the CPU; held while not loaded.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  load finished, checksum good.
REQ-016 error  output  1  load finished, checksum bad.

Function
REQ-017 Byte transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; no other byte is consumed.
REQ-018 States: IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR; in_ready SHALL be 1 only in COUNT, HI, LO, CHECK.
REQ-019 IDLE/DONE/ERR: start=1 -> COUNT; clears done, error, checksum accumulator, ram_addr := BASE_ADDR; cpu_reset := 1.
REQ-020 start SHALL be ignored in COUNT, HI, LO, WRITE, CHECK.
REQ-021 COUNT: accepted byte = word count N; N=0 means 256 words; -> HI.
REQ-022 HI: accepted byte stored as word bits [15:8]; -> LO.
REQ-023 LO: accepted byte forms bits [7:0]; -> WRITE.
REQ-024 WRITE: ram_we=1 for exactly one cycle with ram_addr and ram_wdata stable; next cycle ram_addr increments modulo 2^ADDR_WIDTH (255 wraps to 0); -> HI if words remain, else CHECK.
REQ-025 Checksum SHALL be XOR of the count byte and every data byte accepted.
REQ-026 CHECK: accepted byte equal to checksum -> DONE; otherwise -> ERR.
REQ-027 DONE: done=1, cpu_reset=0, busy=0; held until start or reset.
REQ-028 ERR: error=1, cpu_reset=1, busy=0; RAM contents already written are not reverted.
REQ-029 busy SHALL be 1 in COUNT, HI, LO, WRITE, CHECK; 0 otherwise.
REQ-030 in_valid gaps in any receiving state SHALL stall the FSM with no state or output change.
REQ-031 For WORD_SIZE > 16, upper bits of ram_wdata SHALL be zero; WORD_SIZE < 16 not supported.
REQ-032 All outputs SHALL be registered except in_ready, which is decoded from state.

Reset
REQ-033 reset=0 at a rising edge SHALL force IDLE, cpu_reset=1, ram_we=0, done=0, error=0, busy=0, ram_addr=BASE_ADDR, ram_wdata=0, accumulator=0, from any state.
REQ-034 reset mid-load SHALL abort with no further RAM write; reset dominates start on the same edge.

Verification
REQ-035 start; bytes 02,E2,02,E3,03,xx(checksum=02^E2^02^E3^03) -> writes 0xE202@0, 0xE303@1, done=1, cpu_reset=0.
REQ-036 Same stream with checksum byte off by 1 -> both writes occur, error=1, done=0, cpu_reset=1.
REQ-037 Count 00 with 512 data bytes -> 256 writes, addresses 0..255, final ram_addr wraps to 0, done=1 on correct checksum.
REQ-038 BASE_ADDR=254, N=3 -> writes at 254, 255, 0.
REQ-039 in_valid toggled randomly, start pulsed mid-load -> identical RAM writes and result to gap-free run; start ignored.
REQ-040 reset=0 asserted in LO state -> next cycle IDLE, no ram_we, cpu_reset=1; fresh start then loads correctly.
